// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
//
// Central stall / flush controller for a five-stage CPU pipeline. It merges
// the per-stage stall requests into one per-stage stop vector, tracks a
// multi-cycle divide with a timeout watchdog, and sequences a one-cycle flush
// after an exception or ERET commits in MEM.
//
// Ports
//   cpu_clk_50M   in   1   sole clock, rising edge
//   cpu_rst       in   1   asynchronous reset, active-high
//   stallreq_if   in   1   instruction fetch not ready
//   stallreq_id   in   1   load-use hazard detected in ID
//   div_start     in   1   DIV/DIVU entering EXE (one-cycle pulse)
//   div_ready     in   1   divider result valid (one-cycle pulse)
//   stallreq_mem  in   1   data memory not ready
//   exc_req       in   1   exception / ERET committed in MEM (one-cycle pulse)
//   stall         out  4   1 = stop; bit0 PC, bit1 IF/ID, bit2 ID/EXE,
//                          bit3 EXE/MEM
//   flush         out  1   clear all pipeline registers
//   div_abort     out  1   one-cycle pulse cancelling the divider
//   busy_state    out  2   current FSM state (0 IDLE, 1 DIV_BUSY, 2 FLUSH)
//   stall_cycles  out  32  number of cycles with stall[0] set
//
// Parameters
//   DIV_TIMEOUT   maximum number of cycles spent in DIV_BUSY (<= 63)
//
// Build options
//   STALL_PERF_CNT_EN  when defined, stall_cycles is a free-running 32-bit
//                      counter of PC-stalled cycles; otherwise it is tied to 0
//                      and no counter register exists.
// ---------------------------------------------------------------------------
module pipe_stall_ctrl #(
  parameter int DIV_TIMEOUT = 36
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        div_start,
  input  logic        div_ready,
  input  logic        stallreq_mem,
  input  logic        exc_req,
  output logic [3:0]  stall,
  output logic        flush,
  output logic        div_abort,
  output logic [1:0]  busy_state,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    FLUSH    = 2'd2,
    ILLEGAL  = 2'd3
  } state_t;

  localparam logic [5:0] TIMEOUT_CNT = 6'(DIV_TIMEOUT);

  localparam logic [3:0] STALL_ALL  = 4'b1111;
  localparam logic [3:0] STALL_EXE  = 4'b0111;
  localparam logic [3:0] STALL_ID   = 4'b0011;
  localparam logic [3:0] STALL_PC   = 4'b0001;
  localparam logic [3:0] STALL_NONE = 4'b0000;

  state_t     state;
  state_t     state_nxt;
  logic [5:0] div_cnt;
  logic [5:0] div_cnt_nxt;
  logic [3:0] stall_c;
  logic       flush_c;
  logic       abort_c;
  logic       div_timeout;

  // Priority merge of the stall sources: a memory stall freezes everything
  // up to EXE/MEM, a divide holds ID/EXE and upstream, a load-use hazard
  // holds IF/ID and the PC, and a fetch miss holds only the PC.
  function automatic logic [3:0] stall_encode(
    input logic mem_req,
    input logic div_hold,
    input logic id_req,
    input logic if_req
  );
    logic [3:0] s;
    if (mem_req)       s = STALL_ALL;
    else if (div_hold) s = STALL_EXE;
    else if (id_req)   s = STALL_ID;
    else if (if_req)   s = STALL_PC;
    else               s = STALL_NONE;
    return s;
  endfunction

  assign div_timeout = (div_cnt == TIMEOUT_CNT);

  // State and divide-cycle counter
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state   <= IDLE;
      div_cnt <= '0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_cnt_nxt;
    end
  end

  // Next-state and raw outputs
  always_comb begin
    state_nxt   = state;
    div_cnt_nxt = div_cnt;
    stall_c     = STALL_NONE;
    flush_c     = 1'b0;
    abort_c     = 1'b0;

    case (state)
      IDLE: begin
        // The divide stall starts in the very cycle div_start is seen so
        // the divide operands are held in ID/EXE before the FSM moves.
        stall_c = stall_encode(stallreq_mem, div_start, stallreq_id, stallreq_if);
        if (div_start) begin
          state_nxt   = DIV_BUSY;
          div_cnt_nxt = 6'd1;
        end
      end

      DIV_BUSY: begin
        // The cycle carrying div_ready still stalls so the result can be
        // captured; release happens once back in IDLE. A memory stall
        // overrides the encoding but never pauses the watchdog count.
        stall_c = stall_encode(stallreq_mem, 1'b1, stallreq_id, stallreq_if);
        if (div_ready) begin
          state_nxt = IDLE;
        end else if (div_timeout) begin
          state_nxt = IDLE;
          abort_c   = 1'b1;
        end else begin
          div_cnt_nxt = div_cnt + 6'd1;
        end
      end

      FLUSH: begin
        flush_c   = 1'b1;
        stall_c   = STALL_NONE;
        state_nxt = IDLE;
      end

      default: begin
        // Unreachable encoding: behave like IDLE for stalls but do not
        // accept a divide; recover to IDLE on the next edge.
        stall_c   = stall_encode(stallreq_mem, 1'b0, stallreq_id, stallreq_if);
        state_nxt = IDLE;
      end
    endcase

    // An exception outranks every other request and transition. The
    // pipeline is frozen for the commit cycle, flushed in the next one.
    if (exc_req) begin
      state_nxt   = FLUSH;
      div_cnt_nxt = '0;
      stall_c     = STALL_ALL;
      flush_c     = 1'b0;
      abort_c     = (state == DIV_BUSY);
    end
  end

  // Reset forces the combinational outputs quiet immediately, even between
  // clock edges and regardless of the request inputs.
  assign stall      = cpu_rst ? STALL_NONE : stall_c;
  assign flush      = cpu_rst ? 1'b0       : flush_c;
  assign div_abort  = cpu_rst ? 1'b0       : abort_c;
  assign busy_state = state;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_cnt;

  // Wraps naturally from 32'hFFFF_FFFF to 0.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      perf_cnt <= '0;
    end else if (stall[0]) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign stall_cycles = perf_cnt;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

  localparam int TIMEOUT = 36;

  logic        clk;
  logic        cpu_rst;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        div_start;
  logic        div_ready;
  logic        stallreq_mem;
  logic        exc_req;
  logic [3:0]  stall;
  logic        flush;
  logic        div_abort;
  logic [1:0]  busy_state;
  logic [31:0] stall_cycles;

  int n_vec = 0;
  int n_bad = 0;

  pipe_stall_ctrl #(.DIV_TIMEOUT(TIMEOUT)) dut (
    .cpu_clk_50M  (clk),
    .cpu_rst      (cpu_rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .div_start    (div_start),
    .div_ready    (div_ready),
    .stallreq_mem (stallreq_mem),
    .exc_req      (exc_req),
    .stall        (stall),
    .flush        (flush),
    .div_abort    (div_abort),
    .busy_state   (busy_state),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Behavioural model: "is a divide in flight, and since which cycle", "is a
  // flush owed", plus a running total of PC-stalled cycles.
  // ------------------------------------------------------------------------
  int          cyc_idx;
  int          div_idx;
  bit          m_div;
  bit          m_flush;
  logic [31:0] m_perf;
  int          elapsed;

  logic [3:0]  e_stall;
  logic        e_flush;
  logic        e_abort;
  logic [1:0]  e_busy;

  assign elapsed = cyc_idx - div_idx;

  always_comb begin
    e_stall = 4'b0000;
    e_flush = 1'b0;
    e_abort = 1'b0;
    e_busy  = m_flush ? 2'd2 : (m_div ? 2'd1 : 2'd0);
    if (cpu_rst) begin
      e_busy = 2'd0;
    end else if (exc_req) begin
      e_stall = 4'b1111;
      e_abort = m_div;
    end else if (m_flush) begin
      e_flush = 1'b1;
    end else begin
      if (stallreq_mem)            e_stall = 4'b1111;
      else if (m_div || div_start) e_stall = 4'b0111;
      else if (stallreq_id)        e_stall = 4'b0011;
      else if (stallreq_if)        e_stall = 4'b0001;
      e_abort = m_div && !div_ready && (elapsed >= TIMEOUT);
    end
  end

  always @(posedge clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      cyc_idx <= 0;
      div_idx <= 0;
      m_div   <= 1'b0;
      m_flush <= 1'b0;
      m_perf  <= 32'd0;
    end else begin
      cyc_idx <= cyc_idx + 1;
`ifdef STALL_PERF_CNT_EN
      if (e_stall[0]) m_perf <= m_perf + 32'd1;
`endif
      if (exc_req) begin
        m_flush <= 1'b1;
        m_div   <= 1'b0;
      end else if (m_flush) begin
        m_flush <= 1'b0;
      end else if (m_div) begin
        if (div_ready || elapsed >= TIMEOUT) m_div <= 1'b0;
      end else if (div_start) begin
        m_div   <= 1'b1;
        div_idx <= cyc_idx;
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (!cpu_rst) begin
      check("stall",        {28'd0, stall},      {28'd0, e_stall});
      check("flush",        {31'd0, flush},      {31'd0, e_flush});
      check("div_abort",    {31'd0, div_abort},  {31'd0, e_abort});
      check("busy_state",   {30'd0, busy_state}, {30'd0, e_busy});
      check("stall_cycles", stall_cycles,        m_perf);
      check("stall_flush_excl", {31'd0, (stall != 4'b0000) && flush}, 32'd0);
    end
  end

  // Apply one cycle of inputs shortly after the rising edge.
  task automatic cyc(input logic i_if, input logic i_id, input logic i_ds,
                     input logic i_dr, input logic i_mem, input logic i_exc);
    @(posedge clk);
    #2;
    stallreq_if  = i_if;
    stallreq_id  = i_id;
    div_start    = i_ds;
    div_ready    = i_dr;
    stallreq_mem = i_mem;
    exc_req      = i_exc;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  int n7, nb, na;

  initial begin
    stallreq_if  = 1'b0;
    stallreq_id  = 1'b0;
    div_start    = 1'b0;
    div_ready    = 1'b0;
    stallreq_mem = 1'b0;
    exc_req      = 1'b0;
    cpu_rst      = 1'b1;

    // Reset state
    #5;
    check("rst_stall",  {28'd0, stall}, 32'd0);
    check("rst_flush",  {31'd0, flush}, 32'd0);
    check("rst_abort",  {31'd0, div_abort}, 32'd0);
    check("rst_busy",   {30'd0, busy_state}, 32'd0);
    check("rst_cycles", stall_cycles, 32'd0);
    @(posedge clk);
    #3 cpu_rst = 1'b0;

    // Load-use hazard for one cycle
    cyc(0, 1, 0, 0, 0, 0); #4 check("id_pulse", {28'd0, stall}, 32'h3);
    idle();                #4 check("id_release", {28'd0, stall}, 32'h0);

    // Priority between simultaneous requests
    cyc(1, 1, 0, 0, 1, 0); #4 check("prio_mem", {28'd0, stall}, 32'hF);
    cyc(1, 1, 0, 0, 0, 0); #4 check("prio_id",  {28'd0, stall}, 32'h3);
    cyc(1, 0, 0, 0, 0, 0); #4 check("prio_if",  {28'd0, stall}, 32'h1);
    cyc(0, 0, 0, 1, 0, 0); #4 check("stray_ready", {28'd0, stall}, 32'h0);

    // Divide completing 10 cycles after start
    n7 = 0; nb = 0;
    cyc(0, 0, 1, 0, 0, 0); #4;
    n7 += int'(stall == 4'b0111); nb += int'(busy_state == 2'd1);
    for (int i = 1; i < 10; i++) begin
      cyc(0, 0, i == 4, 0, 0, 0); #4;
      n7 += int'(stall == 4'b0111); nb += int'(busy_state == 2'd1);
    end
    cyc(0, 0, 0, 1, 0, 0); #4;
    n7 += int'(stall == 4'b0111); nb += int'(busy_state == 2'd1);
    check("div_ready_cycle_stall", {28'd0, stall}, 32'h7);
    idle(); #4;
    n7 += int'(stall == 4'b0111); nb += int'(busy_state == 2'd1);
    check("div_done_stall", {28'd0, stall}, 32'h0);
    check("div_done_busy", {30'd0, busy_state}, 32'd0);
    check("div_stall_cycles", n7, 11);
    check("div_busy_cycles", nb, 10);

    // Divide timing out, with a memory stall in the middle
    nb = 0; na = 0;
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 0, 0, (i == 5) || (i == 6), 0); #4;
      nb += int'(busy_state == 2'd1); na += int'(div_abort == 1'b1);
    end
    check("timeout_busy_cycles", nb, TIMEOUT);
    check("timeout_abort_pulses", na, 1);
    check("timeout_stall", {28'd0, stall}, 32'h0);

    // Exception during a divide with a memory stall pending
    cyc(0, 0, 1, 0, 0, 0);
    repeat (3) idle();
    cyc(0, 0, 0, 0, 1, 1); #4;
    check("exc_stall", {28'd0, stall}, 32'hF);
    check("exc_abort", {31'd0, div_abort}, 32'd1);
    check("exc_flush", {31'd0, flush}, 32'd0);
    idle(); #4;
    check("flush_flush", {31'd0, flush}, 32'd1);
    check("flush_stall", {28'd0, stall}, 32'h0);
    idle(); #4;
    check("after_flush_busy", {30'd0, busy_state}, 32'd0);

    // Back-to-back exceptions re-enter FLUSH
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 1, 0, 0, 1); #4 check("reexc_busy", {30'd0, busy_state}, 32'd2);
    idle();                #4 check("reexc_flush", {31'd0, flush}, 32'd1);
    idle();                #4 check("reexc_idle", {30'd0, busy_state}, 32'd0);

    // Asynchronous reset in the middle of a divide
    cyc(0, 0, 1, 0, 0, 0);
    repeat (3) idle();
    @(posedge clk);
    #5 cpu_rst = 1'b1;
    #1;
    check("arst_busy",  {30'd0, busy_state}, 32'd0);
    check("arst_stall", {28'd0, stall}, 32'h0);
    check("arst_abort", {31'd0, div_abort}, 32'd0);
    #1 cpu_rst = 1'b0;
    idle(); #4;
    check("arst_after_busy",  {30'd0, busy_state}, 32'd0);
    check("arst_after_stall", {28'd0, stall}, 32'h0);

    // Performance counter: 5 fetch stalls then 3 memory stalls
    @(posedge clk);
    #3 cpu_rst = 1'b1;
    #2 cpu_rst = 1'b0;
    repeat (5) cyc(1, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 0);
    idle(); #4;
`ifdef STALL_PERF_CNT_EN
    check("perf_cycles", stall_cycles, 32'd8);
`else
    check("perf_cycles", stall_cycles, 32'd0);
`endif
    idle();
    @(posedge clk); #3;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
